// File: rtl/dpi_call_sequencer_if.sv
// Call-argument handshake bundle between the sequencer and the DPI call stage.
//   call_valid : argument valid (sequencer -> consumer)
//   call_ready : consumer accepts argument (consumer -> sequencer)
//   call_arg   : argument for one hello_world(int) invocation
interface dpi_call_sequencer_if #(
  parameter int unsigned ARG_W = 32
);
  logic             call_valid;
  logic             call_ready;
  logic [ARG_W-1:0] call_arg;

  modport master (output call_valid, output call_arg, input call_ready);
  modport slave  (input call_valid, input call_arg, output call_ready);
endinterface

// File: rtl/dpi_call_sequencer.sv
// Generates the arithmetic argument sequence base, base+step, ... and offers
// each value on a valid/ready handshake to the DPI call stage.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_start             : start request (honoured in IDLE, or DONE after the pulse)
//   i_cfg_base/step     : first argument and per-call increment (wraps)
//   i_cfg_count         : number of calls in the sequence
//   i_cfg_gap           : idle cycles after each accepted call
//   call_if (master)    : call_valid / call_ready / call_arg
//   o_busy              : high while in ISSUE or GAP
//   o_done              : one-cycle pulse on entry to DONE
//   o_calls_issued      : handshakes completed in the current sequence
module dpi_call_sequencer #(
  parameter int unsigned ARG_W   = 32,
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned GAP_W   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [ARG_W-1:0]         i_cfg_base,
  input  logic [ARG_W-1:0]         i_cfg_step,
  input  logic [COUNT_W-1:0]       i_cfg_count,
  input  logic [GAP_W-1:0]         i_cfg_gap,
  dpi_call_sequencer_if.master     call_if,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [COUNT_W-1:0]       o_calls_issued
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_t;

  state_t               r_state,   w_state_nxt;
  logic [ARG_W-1:0]     r_step,    w_step_nxt;
  logic [COUNT_W-1:0]   r_count,   w_count_nxt;
  logic [GAP_W-1:0]     r_gap,     w_gap_nxt;
  logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt_nxt;
  logic [ARG_W-1:0]     r_arg,     w_arg_nxt;
  logic                 r_valid,   w_valid_nxt;
  logic                 r_busy,    w_busy_nxt;
  logic                 r_done,    w_done_nxt;
  logic [COUNT_W-1:0]   r_issued,  w_issued_nxt;
  logic                 w_hs;
  logic                 w_start_ok;
  logic [COUNT_W-1:0]   w_issued_inc;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_count   <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_arg     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_issued  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_count   <= w_count_nxt;
      r_gap     <= w_gap_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_arg     <= w_arg_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_issued  <= w_issued_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_count_nxt   = r_count;
    w_gap_nxt     = r_gap;
    w_gap_cnt_nxt = r_gap_cnt;
    w_arg_nxt     = r_arg;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_issued_nxt  = r_issued;

    w_hs         = r_valid & call_if.call_ready;
    w_issued_inc = r_issued + COUNT_W'(1);
    // The cycle carrying the done pulse is the DONE entry cycle; start is ignored there.
    w_start_ok   = i_start & ((r_state == S_IDLE) | ((r_state == S_DONE) & ~r_done));

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_step_nxt   = i_cfg_step;
          w_count_nxt  = i_cfg_count;
          w_gap_nxt    = i_cfg_gap;
          w_arg_nxt    = i_cfg_base;
          w_issued_nxt = '0;
          if (i_cfg_count == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_ISSUE;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (w_hs) begin
          w_issued_nxt = w_issued_inc;
          w_arg_nxt    = r_arg + r_step;
          if (w_issued_inc == r_count) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
          end else if (r_gap != '0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = r_gap;
            w_valid_nxt   = 1'b0;
          end
        end
      end
      S_GAP: begin
        // Leaving at count 1 gives exactly r_gap idle cycles.
        if (r_gap_cnt == GAP_W'(1)) begin
          w_state_nxt = S_ISSUE;
          w_valid_nxt = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign call_if.call_valid = r_valid;
  assign call_if.call_arg   = r_arg;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_calls_issued     = r_issued;

endmodule

// File: tb/tb_dpi_call_sequencer.sv
// Directed self-checking bench for dpi_call_sequencer.
module tb_dpi_call_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] cfg_base;
  logic [31:0] cfg_step;
  logic [15:0] cfg_count;
  logic [7:0]  cfg_gap;
  logic        busy;
  logic        done;
  logic [15:0] calls_issued;

  int n_cmp;
  int n_err;

  dpi_call_sequencer_if #(.ARG_W(32)) bus ();

  dpi_call_sequencer #(.ARG_W(32), .COUNT_W(16), .GAP_W(8)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_cfg_base     (cfg_base),
    .i_cfg_step     (cfg_step),
    .i_cfg_count    (cfg_count),
    .i_cfg_gap      (cfg_gap),
    .call_if        (bus),
    .o_busy         (busy),
    .o_done         (done),
    .o_calls_issued (calls_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [31:0] b, input logic [31:0] s,
                           input logic [15:0] c, input logic [7:0] g);
    cfg_base  = b;
    cfg_step  = s;
    cfg_count = c;
    cfg_gap   = g;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    logic [5:0]  rdy_pat;
    logic [31:0] exp_arg;
    int          hs;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    cfg_base = '0; cfg_step = '0; cfg_count = '0; cfg_gap = '0;
    bus.call_ready = 1'b0;
    tick();
    tick();
    check("rst_valid",  32'(bus.call_valid), 32'd0);
    check("rst_arg",    bus.call_arg,        32'd0);
    check("rst_busy",   32'(busy),           32'd0);
    check("rst_done",   32'(done),           32'd0);
    check("rst_issued", 32'(calls_issued),   32'd0);
    reset = 1'b0;
    tick();

    // Single call
    bus.call_ready = 1'b1;
    start_seq(32'd10, 32'd1, 16'd1, 8'd0);
    check("t1_valid", 32'(bus.call_valid), 32'd1);
    check("t1_arg",   bus.call_arg,        32'd10);
    check("t1_busy",  32'(busy),           32'd1);
    tick();
    check("t1_done",   32'(done),         32'd1);
    check("t1_vlow",   32'(bus.call_valid), 32'd0);
    check("t1_issued", 32'(calls_issued), 32'd1);
    check("t1_next",   bus.call_arg,      32'd11);
    tick();
    check("t1_done_once", 32'(done), 32'd0);

    // Back-to-back, step 5
    start_seq(32'd0, 32'd5, 16'd4, 8'd0);
    for (int i = 0; i < 4; i++) begin
      check("t2_valid", 32'(bus.call_valid), 32'd1);
      check("t2_arg",   bus.call_arg,        32'(5 * i));
      tick();
    end
    check("t2_done",   32'(done),           32'd1);
    check("t2_busy",   32'(busy),           32'd0);
    check("t2_issued", 32'(calls_issued),   32'd4);
    check("t2_final",  bus.call_arg,        32'd20);
    tick();
    check("t2_done_once", 32'(done), 32'd0);
    check("t2_busy_after", 32'(busy), 32'd0);

    // Gap of 2 between calls: valid pattern 1,0,0,1,0,0,1 then DONE
    start_seq(32'd7, 32'd1, 16'd3, 8'd2);
    for (int c = 0; c < 7; c++) begin
      check("t3_valid", 32'(bus.call_valid), (c % 3 == 0) ? 32'd1 : 32'd0);
      if (c % 3 == 0) check("t3_arg", bus.call_arg, 32'(7 + c / 3));
      check("t3_busy", 32'(busy), 32'd1);
      tick();
    end
    check("t3_done",   32'(done),         32'd1);
    check("t3_issued", 32'(calls_issued), 32'd3);
    tick();

    // Stalls: ready 0,0,1,0,1,1
    rdy_pat = 6'b110100;
    bus.call_ready = 1'b0;
    start_seq(32'd100, 32'd3, 16'd3, 8'd0);
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      bus.call_ready = rdy_pat[c];
      exp_arg = 32'd100 + 32'(3 * hs);
      check("t4_valid", 32'(bus.call_valid), 32'd1);
      check("t4_arg",   bus.call_arg,        exp_arg);
      check("t4_issued", 32'(calls_issued),  32'(hs));
      tick();
      if (rdy_pat[c]) hs++;
    end
    check("t4_done",   32'(done),         32'd1);
    check("t4_issued_end", 32'(calls_issued), 32'd3);
    bus.call_ready = 1'b1;
    tick();

    // Wrap upward
    start_seq(32'hFFFF_FFFE, 32'd1, 16'd3, 8'd0);
    check("t5_arg0", bus.call_arg, 32'hFFFF_FFFE);
    tick();
    check("t5_arg1", bus.call_arg, 32'hFFFF_FFFF);
    tick();
    check("t5_arg2", bus.call_arg, 32'h0000_0000);
    tick();
    check("t5_done", 32'(done), 32'd1);
    check("t5_final", bus.call_arg, 32'h0000_0001);
    tick();

    // Negative step
    start_seq(32'd1, 32'hFFFF_FFFF, 16'd3, 8'd0);
    check("t6_arg0", bus.call_arg, 32'h0000_0001);
    tick();
    check("t6_arg1", bus.call_arg, 32'h0000_0000);
    tick();
    check("t6_arg2", bus.call_arg, 32'hFFFF_FFFF);
    tick();
    check("t6_done", 32'(done), 32'd1);
    check("t6_final", bus.call_arg, 32'hFFFF_FFFE);
    tick();

    // Zero count: done pulse, no call
    start_seq(32'd55, 32'd1, 16'd0, 8'd0);
    check("t7_valid",  32'(bus.call_valid), 32'd0);
    check("t7_done",   32'(done),           32'd1);
    check("t7_busy",   32'(busy),           32'd0);
    check("t7_issued", 32'(calls_issued),   32'd0);
    tick();
    check("t7_done_once", 32'(done), 32'd0);
    check("t7_valid2", 32'(bus.call_valid), 32'd0);

    // Start while busy is ignored
    start_seq(32'd50, 32'd2, 16'd3, 8'd1);
    check("t8_arg0", bus.call_arg, 32'd50);
    tick();
    check("t8_gap", 32'(bus.call_valid), 32'd0);
    cfg_base = 32'd999; cfg_step = 32'd7; cfg_count = 16'd1; cfg_gap = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t8_valid1", 32'(bus.call_valid), 32'd1);
    check("t8_arg1",   bus.call_arg,        32'd52);
    tick();
    check("t8_gap2", 32'(bus.call_valid), 32'd0);
    tick();
    check("t8_arg2", bus.call_arg, 32'd54);
    tick();
    check("t8_done",   32'(done),         32'd1);
    check("t8_issued", 32'(calls_issued), 32'd3);
    tick();

    // Reset mid-sequence, then restart
    start_seq(32'd200, 32'd1, 16'd5, 8'd0);
    tick();
    tick();
    check("t9_issued_pre", 32'(calls_issued), 32'd2);
    check("t9_arg_pre",    bus.call_arg,      32'd202);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t9_valid_rst",  32'(bus.call_valid), 32'd0);
    check("t9_issued_rst", 32'(calls_issued),   32'd0);
    check("t9_busy_rst",   32'(busy),           32'd0);
    check("t9_arg_rst",    bus.call_arg,        32'd0);
    start_seq(32'd300, 32'd1, 16'd2, 8'd0);
    check("t9_arg0", bus.call_arg, 32'd300);
    tick();
    check("t9_arg1", bus.call_arg, 32'd301);
    tick();
    check("t9_done",   32'(done),         32'd1);
    check("t9_issued", 32'(calls_issued), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dpi_call_sequencer.md
Name: dpi_call_sequencer

Overview:
Upstream stage that feeds the DPI-C call stage. It generates a programmed sequence of integer call arguments (base, base+step, ...) and presents each one on a valid/ready handshake. The downstream block consumes each argument as one `hello_world(int)` invocation. `done` tells the downstream/top that the sequence is exhausted so it can `$finish`.

Parameters:
ARG_W, 32, width of the call argument (matches DPI `int`)
COUNT_W, 16, width of the call-count and issued-count fields
GAP_W, 8, width of the inter-call idle-gap field

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  start request; sampled only in IDLE or DONE
cfg_base  input  ARG_W  first argument value
cfg_step  input  ARG_W  per-call increment (two's complement, wraps)
cfg_count  input  COUNT_W  number of calls to issue
cfg_gap  input  GAP_W  idle cycles inserted after each accepted call
call_valid  output  1  argument valid to downstream
call_ready  input  1  downstream accepts argument
call_arg  output  ARG_W  current call argument
busy  output  1  high in ISSUE or GAP
done  output  1  one-cycle pulse on entry to DONE
calls_issued  output  COUNT_W  handshakes completed in current sequence

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and reset.
- Reset, including mid-sequence, forces the following on the next edge:
  - state=IDLE
  - call_valid=0, call_arg=0, busy=0, done=0, calls_issued=0
  - all latched config cleared
- States: IDLE, ISSUE, GAP, DONE.
- IDLE/DONE, start=1:
  - Latch cfg_base, cfg_step, cfg_count and cfg_gap.
  - Clear calls_issued.
  - If cfg_count=0: go to DONE; done pulses the following cycle; no call issued.
  - Else: go to ISSUE with call_arg=cfg_base. call_valid rises the cycle after start (1-cycle latency).
- start while busy is ignored. Latched config does not change mid-sequence.
- ISSUE:
  - call_valid=1.
  - call_arg is held stable while call_ready=0; no timeout.
- Handshake = call_valid & call_ready in the same cycle. On handshake:
  - calls_issued increments.
  - call_arg <= call_arg + step, truncated to ARG_W (modulo 2^ARG_W wrap).
- Routing after a handshake:
  - If calls_issued+1 == count: go to DONE; call_valid drops the next cycle.
  - Else if gap=0: stay in ISSUE with call_valid held high, giving back-to-back calls (one per cycle when call_ready is held).
  - Else: go to GAP, load the gap counter with gap, call_valid=0.
- GAP: decrement the counter each cycle. At counter==1, return to ISSUE, so there are exactly gap cycles with call_valid=0.
- DONE:
  - done=1 for the entry cycle only, then 0.
  - busy=0, call_valid=0.
  - calls_issued and the final call_arg (last+step) are held until the next start or reset.
- start in the same cycle as entry into DONE is not sampled. start is sampled from the following cycle onward.
- calls_issued never exceeds count, so there is no overflow; count max = 2^COUNT_W-1.
- call_ready while call_valid=0 is ignored.

Test Plan:
- reset, then start with base=10, step=1, count=1, gap=0, ready=1 -> one handshake with arg=10; done pulses once, 1 cycle after the handshake; calls_issued=1.
- base=0, step=5, count=4, gap=0, ready held 1 -> call_valid high 4 consecutive cycles with args 0, 5, 10, 15; single done pulse; busy low afterwards.
- base=7, step=1, count=3, gap=2, ready=1 -> args 7, 8, 9; exactly 2 call_valid-low cycles between calls; total 7 cycles from first valid to DONE.
- count=3, ready toggled 0,0,1,0,1,1 -> arg held stable during stalls; handshake args 0, step, 2*step in order; no duplicates or drops.
- base=32'hFFFF_FFFE, step=1, count=3 -> args FFFF_FFFE, FFFF_FFFF, 0000_0000 (wrap); step=-1 (32'hFFFF_FFFF) from base=1 -> 1, 0, FFFF_FFFF.
- count=0 start -> no call_valid, done pulse; start pulsed mid-sequence is ignored; reset asserted mid-sequence (after 2 of 5 calls) -> call_valid=0 and calls_issued=0 next cycle; a new start then restarts from the new base.
